// File: rtl/intr_ctrl.sv
// Interrupt controller and register-bank sequencer for the jacaranda-8 core.
// Latches edge-triggered requests, masks them, takes the lowest-index eligible
// source at an instruction boundary and holds the interrupt bank until reti.
module intr_ctrl #(
  parameter int unsigned NSRC     = 4,
  parameter logic [7:0]  VEC_BASE = 8'hE0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NSRC-1:0] irq_in,
  input  logic            mask_wr,
  input  logic [NSRC-1:0] mask_wdata,
  input  logic            instr_done,
  input  logic            reti,
  input  logic [7:0]      cur_pc,
  output logic            intr_take,
  output logic [7:0]      intr_vec,
  output logic            intr_en,
  output logic [7:0]      ret_pc,
  output logic [NSRC-1:0] pending,
  output logic [NSRC-1:0] mask,
  output logic [2:0]      active_id
);

  typedef enum logic [0:0] {StIdle, StService} state_e;

  state_e          r_state;
  logic [NSRC-1:0] r_irq_prev;
  logic [NSRC-1:0] r_pending;
  logic [NSRC-1:0] r_mask;
  logic            r_take;
  logic [7:0]      r_vec;
  logic            r_en;
  logic [7:0]      r_ret_pc;
  logic [2:0]      r_active_id;

  logic [NSRC-1:0] w_rise;
  logic [NSRC-1:0] w_eligible;
  logic [NSRC-1:0] w_clear;
  logic [2:0]      w_winner;
  logic            w_take_now;
  logic [7:0]      w_vec;

  // Edge detect, eligibility, fixed-priority pick and the take decision.
  always_comb begin
    w_rise     = irq_in & ~r_irq_prev;
    w_eligible = r_pending & r_mask;
    w_winner   = '0;
    // Scan from the top so the lowest set index wins.
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (w_eligible[i]) w_winner = 3'(i);
    end
    w_take_now = (r_state == StIdle) && instr_done && (|w_eligible);
    w_vec      = VEC_BASE + {3'b000, w_winner, 2'b00};
    w_clear    = '0;
    for (int i = 0; i < NSRC; i++) begin
      w_clear[i] = w_take_now && (w_winner == 3'(i));
    end
  end

  // Single-process FSM with registered outputs; reset is synchronous, active-low.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= StIdle;
      // All ones so lines already high at release are not seen as edges.
      r_irq_prev  <= '1;
      r_pending   <= '0;
      r_mask      <= '0;
      r_take      <= 1'b0;
      r_vec       <= '0;
      r_en        <= 1'b0;
      r_ret_pc    <= '0;
      r_active_id <= '0;
    end else begin
      r_irq_prev <= irq_in;
      // A new edge in the clear cycle keeps the bit set.
      r_pending  <= (r_pending & ~w_clear) | w_rise;
      if (mask_wr) r_mask <= mask_wdata;
      r_take <= w_take_now;
      r_vec  <= w_take_now ? w_vec : 8'h00;
      unique case (r_state)
        StIdle: begin
          if (w_take_now) begin
            r_ret_pc    <= cur_pc;
            r_active_id <= w_winner;
            r_en        <= 1'b1;
            r_state     <= StService;
          end
        end
        StService: begin
          if (instr_done && reti) begin
            r_en        <= 1'b0;
            r_active_id <= '0;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign intr_take = r_take;
  assign intr_vec  = r_vec;
  assign intr_en   = r_en;
  assign ret_pc    = r_ret_pc;
  assign pending   = r_pending;
  assign mask      = r_mask;
  assign active_id = r_active_id;

endmodule
